// File: rtl/conv_pkg.sv
// Shared definitions for the ID1000500A conv IP: default widths and engine FSM states.
package conv_pkg;

    localparam int unsigned CONV_DATA_W = 8;
    localparam int unsigned CONV_ADDR_W = 5;
    localparam int unsigned CONV_RES_W  = 32;

    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StLast,
        StWrite,
        StDone
    } conv_state_e;

endpackage

// File: rtl/conv_mac.sv
// Registered unsigned multiply-accumulate with synchronous clear and clock enable.
module conv_mac #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RES_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_a,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  logic                  i_add,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [RES_WIDTH-1:0]  o_acc
);

    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [RES_WIDTH-1:0]    r_acc;

    assign w_prod = i_a * i_b;
    assign o_acc  = r_acc;

    // Clear wins over add: the first tap of a result discards stale RAM data.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_acc <= '0;
        end else if (i_en) begin
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_add) begin
                r_acc <= r_acc + RES_WIDTH'(w_prod);
            end
        end
    end

endmodule

// File: rtl/id1000500a_conv_core.sv
// Convolution engine: reads X and Y sample RAMs and writes z[i] = sum_j x[j]*y[i-j] to Z,
// one tap per cycle, then flags completion with a sticky done and a one-cycle done_pulse.
module id1000500a_conv_core
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CONV_DATA_W,
    parameter int unsigned ADDR_WIDTH = CONV_ADDR_W,
    parameter int unsigned RES_WIDTH  = CONV_RES_W
) (
    input  logic                  clk,
    input  logic                  rst_a,
    input  logic                  en_s,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   size_x,
    input  logic [ADDR_WIDTH:0]   size_y,
    output logic [ADDR_WIDTH-1:0] memx_addr,
    input  logic [DATA_WIDTH-1:0] memx_data,
    output logic [ADDR_WIDTH-1:0] memy_addr,
    input  logic [DATA_WIDTH-1:0] memy_data,
    output logic [ADDR_WIDTH:0]   memz_addr,
    output logic [RES_WIDTH-1:0]  memz_data,
    output logic                  memz_we,
    output logic                  busy,
    output logic                  done,
    output logic                  done_pulse
);

    // One spare bit over the Z index so i+1 and sx+sy never wrap.
    localparam int unsigned IW = ADDR_WIDTH + 2;
    localparam logic [IW-1:0] ONE = IW'(1);
    localparam logic [IW-1:0] TWO = IW'(2);

    conv_state_e           r_state, w_state_d;
    logic [ADDR_WIDTH:0]   r_i, w_i_d;
    logic [ADDR_WIDTH-1:0] r_j, w_j_d;
    logic [ADDR_WIDTH:0]   r_size_x, w_size_x_d;
    logic [ADDR_WIDTH:0]   r_size_y, w_size_y_d;
    logic                  r_done, w_done_d;

    logic [IW-1:0] w_i_ext, w_j_ext, w_sx_ext, w_sy_ext;
    logic [IW-1:0] w_i_nxt, w_i_nxt2, w_jlo, w_jlo_nxt, w_jhi, w_i_last;
    logic          w_first, w_mac_add;
    logic [RES_WIDTH-1:0] w_acc;

    assign w_i_ext  = IW'(r_i);
    assign w_j_ext  = IW'(r_j);
    assign w_sx_ext = IW'(r_size_x);
    assign w_sy_ext = IW'(r_size_y);

    // jlo = max(0, i-sy+1) written as (i+1 > sy) to stay unsigned.
    assign w_i_nxt   = w_i_ext + ONE;
    assign w_i_nxt2  = w_i_nxt + ONE;
    assign w_jlo     = (w_i_nxt > w_sy_ext) ? (w_i_nxt - w_sy_ext) : '0;
    assign w_jlo_nxt = (w_i_nxt2 > w_sy_ext) ? (w_i_nxt2 - w_sy_ext) : '0;
    assign w_jhi     = (w_i_ext < w_sx_ext) ? w_i_ext : (w_sx_ext - ONE);
    assign w_i_last  = w_sx_ext + w_sy_ext - TWO;

    assign w_first   = (r_state == StCalc) && (w_j_ext == w_jlo);
    assign w_mac_add = ((r_state == StCalc) && !w_first) || (r_state == StLast);

    conv_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .RES_WIDTH  (RES_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst_a (rst_a),
        .i_en  (en_s),
        .i_clr (w_first),
        .i_add (w_mac_add),
        .i_a   (memx_data),
        .i_b   (memy_data),
        .o_acc (w_acc)
    );

    always_comb begin
        w_state_d  = r_state;
        w_i_d      = r_i;
        w_j_d      = r_j;
        w_size_x_d = r_size_x;
        w_size_y_d = r_size_y;
        w_done_d   = r_done;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_size_x_d = size_x;
                    w_size_y_d = size_y;
                    w_i_d      = '0;
                    w_j_d      = '0;
                    w_done_d   = 1'b0;
                    if (size_x == '0 || size_y == '0) begin
                        w_state_d = StDone;
                        w_done_d  = 1'b1;
                    end else begin
                        w_state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (w_j_ext == w_jhi) begin
                    w_state_d = StLast;
                end else begin
                    w_j_d = r_j + 1'b1;
                end
            end
            StLast: w_state_d = StWrite;
            StWrite: begin
                if (w_i_ext == w_i_last) begin
                    w_state_d = StDone;
                    w_done_d  = 1'b1;
                end else begin
                    w_i_d     = r_i + 1'b1;
                    w_j_d     = ADDR_WIDTH'(w_jlo_nxt);
                    w_state_d = StCalc;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_state  <= StIdle;
            r_i      <= '0;
            r_j      <= '0;
            r_size_x <= '0;
            r_size_y <= '0;
            r_done   <= 1'b0;
        end else if (en_s) begin
            r_state  <= w_state_d;
            r_i      <= w_i_d;
            r_j      <= w_j_d;
            r_size_x <= w_size_x_d;
            r_size_y <= w_size_y_d;
            r_done   <= w_done_d;
        end
    end

    assign memx_addr  = r_j;
    assign memy_addr  = ADDR_WIDTH'(w_i_ext - w_j_ext);
    assign memz_addr  = r_i;
    assign memz_we    = (r_state == StWrite);
    assign memz_data  = memz_we ? w_acc : '0;
    assign busy       = (r_state == StCalc) || (r_state == StLast) || (r_state == StWrite);
    assign done       = r_done;
    assign done_pulse = (r_state == StDone);

endmodule

// File: tb/tb_id1000500a_conv_core.sv
// Randomised self-checking bench for id1000500a_conv_core against a direct convolution model.
module tb_id1000500a_conv_core;

    logic        clk = 1'b0;
    logic        rst_a, en_s, start;
    logic [5:0]  size_x, size_y;
    logic [4:0]  memx_addr, memy_addr;
    logic [7:0]  memx_data, memy_data;
    logic [5:0]  memz_addr;
    logic [31:0] memz_data;
    logic        memz_we, busy, done, done_pulse;

    logic [7:0] mx [32];
    logic [7:0] my [32];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int unsigned     wr_addr [$];
    longint unsigned wr_data [$];
    bit              pulse_seen;
    int              pulse_cyc;
    int              pulse_cnt;
    int              last_lat;

    id1000500a_conv_core u_dut (
        .clk        (clk),
        .rst_a      (rst_a),
        .en_s       (en_s),
        .start      (start),
        .size_x     (size_x),
        .size_y     (size_y),
        .memx_addr  (memx_addr),
        .memx_data  (memx_data),
        .memy_addr  (memy_addr),
        .memy_data  (memy_data),
        .memz_addr  (memz_addr),
        .memz_data  (memz_data),
        .memz_we    (memz_we),
        .busy       (busy),
        .done       (done),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        memx_data <= mx[memx_addr];
        memy_data <= my[memy_addr];
    end

    // Inputs change just after posedge, so en_s here is the value the next edge will see.
    always @(negedge clk) begin
        if (rst_a && en_s) begin
            if (memz_we) begin
                wr_addr.push_back(int'(memz_addr));
                wr_data.push_back(longint'(memz_data));
            end
            if (done_pulse) begin
                pulse_cnt++;
                if (!pulse_seen) begin
                    pulse_seen = 1'b1;
                    pulse_cyc  = cyc;
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic run_case(input int sx, input int sy, input int gap_at, input int gap_len,
                            input int restart_at, input string nm);
        longint unsigned exp_z [64];
        int n_exp, lat, t0, taps;
        n_exp = (sx == 0 || sy == 0) ? 0 : sx + sy - 1;
        lat   = 1;
        for (int i = 0; i < n_exp; i++) begin
            exp_z[i] = 0;
            taps     = 0;
            for (int j = 0; j < sx; j++) begin
                if (i - j >= 0 && i - j < sy) begin
                    exp_z[i] += longint'(mx[j]) * longint'(my[i-j]);
                    taps++;
                end
            end
            lat += taps + 2;
        end
        wr_addr.delete();
        wr_data.delete();
        pulse_seen = 1'b0;
        pulse_cnt  = 0;

        @(posedge clk) #1;
        start  = 1'b1;
        size_x = 6'(sx);
        size_y = 6'(sy);
        t0     = cyc + 1;
        @(posedge clk) #1;
        start = 1'b0;
        check_val({nm, "_busy_on"}, busy, n_exp > 0);
        check_val({nm, "_done_clr"}, done, n_exp == 0);

        for (int k = 1; k < 4000 && !pulse_seen; k++) begin
            if (k == gap_at) en_s = 1'b0;
            if (k == gap_at + gap_len) en_s = 1'b1;
            if (k == restart_at) begin
                start  = 1'b1;
                size_x = 6'd1;
                size_y = 6'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk) #1;
        end
        en_s  = 1'b1;
        start = 1'b0;
        check_val({nm, "_timeout"}, pulse_seen, 1);
        last_lat = pulse_seen ? pulse_cyc - t0 + 1 : -1;

        @(posedge clk) #1;
        @(negedge clk);
        check_val({nm, "_lat"}, last_lat, lat + gap_len);
        check_val({nm, "_done"}, done, 1);
        check_val({nm, "_busy_off"}, busy, 0);
        check_val({nm, "_pulse_1cyc"}, pulse_cnt, 1);
        check_val({nm, "_nwr"}, wr_addr.size(), n_exp);
        for (int i = 0; i < n_exp && i < wr_addr.size(); i++) begin
            check_val($sformatf("%s_zaddr%0d", nm, i), wr_addr[i], i);
            check_val($sformatf("%s_z%0d", nm, i), wr_data[i], exp_z[i]);
        end
    endtask

    task automatic load_case1();
        for (int i = 0; i < 32; i++) begin
            mx[i] = 8'(i + 1);
            my[i] = 8'd1;
        end
    endtask

    task automatic check_all_zero(input string nm);
        check_val({nm, "_busy"}, busy, 0);
        check_val({nm, "_done"}, done, 0);
        check_val({nm, "_pulse"}, done_pulse, 0);
        check_val({nm, "_we"}, memz_we, 0);
        check_val({nm, "_xaddr"}, memx_addr, 0);
        check_val({nm, "_yaddr"}, memy_addr, 0);
        check_val({nm, "_zaddr"}, memz_addr, 0);
        check_val({nm, "_zdata"}, memz_data, 0);
    endtask

    initial begin
        rst_a  = 1'b0;
        en_s   = 1'b1;
        start  = 1'b0;
        size_x = '0;
        size_y = '0;
        for (int i = 0; i < 32; i++) begin
            mx[i] = '0;
            my[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_a = 1'b1;

        load_case1();
        run_case(3, 3, 0, 0, 0, "c1");
        check_val("c1_lat_abs", last_lat, 20);

        mx[0] = 8'd7;
        for (int i = 0; i < 4; i++) my[i] = 8'(i + 1);
        run_case(1, 4, 0, 0, 0, "c2");

        run_case(0, 5, 0, 0, 0, "c3");
        check_val("c3_lat_abs", last_lat, 1);

        for (int i = 0; i < 32; i++) begin
            mx[i] = 8'd255;
            my[i] = 8'd255;
        end
        run_case(32, 32, 0, 0, 0, "c4");
        check_val("c4_z31", wr_data.size() > 31 ? wr_data[31] : 64'd0, 2080800);
        check_val("c4_last_addr", wr_addr.size() > 62 ? wr_addr[62] : 0, 62);

        load_case1();
        run_case(3, 3, 4, 5, 0, "c5_gap");
        check_val("c5_lat_abs", last_lat, 25);

        run_case(3, 3, 0, 0, 3, "c6_restart");

        @(posedge clk) #1;
        start  = 1'b1;
        size_x = 6'd3;
        size_y = 6'd3;
        @(posedge clk) #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_a = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk) #1;
        rst_a = 1'b1;
        run_case(3, 3, 0, 0, 0, "c7_rerun");

        for (int r = 0; r < 8; r++) begin
            int sx, sy;
            sx = (r == 7) ? 0 : int'($urandom_range(1, 32));
            sy = int'($urandom_range(1, 32));
            for (int i = 0; i < 32; i++) begin
                mx[i] = 8'($urandom);
                my[i] = 8'($urandom);
            end
            run_case(sx, sy, (r == 2) ? 6 : 0, (r == 2) ? 3 : 0, 0, $sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
